// File: rtl/bram_stream_pkg.sv
// Shared types and helpers for the sample-buffer Port-A stream writer.
package bram_stream_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    localparam int DEFAULT_DEPTH       = 16384;
    localparam int DEFAULT_BLOCK_WORDS = 1024;

    // Circular-buffer successor of a word index.
    function automatic int unsigned next_index(input int unsigned idx, input int unsigned depth);
        return (idx + 1 == depth) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/bram_stream_writer.sv
// Port-A stream writer: valid/ready samples into a circular BRAM buffer with block interrupts.
// Build option BRAM_STREAM_WRITER_DROP_ON_FULL_EN: keep s_ready high in RUN and count dropped words.
module bram_stream_writer
    import bram_stream_pkg::*;
#(
    parameter int BRAM_ADDR_WIDTH = 16,
    parameter int BRAM_DATA_WIDTH = 32,
    parameter int DEPTH           = DEFAULT_DEPTH,
    parameter int BLOCK_WORDS     = DEFAULT_BLOCK_WORDS,
    localparam int PTR_W          = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       clear,
    input  logic [BRAM_DATA_WIDTH-1:0] s_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    // One bit wider than an index so an out-of-range software pointer is observable.
    input  logic [PTR_W:0]             rd_ptr,
    output logic [PTR_W-1:0]           wr_ptr,
    output logic                       block_irq,
    output logic [31:0]                block_count,
    output logic [31:0]                overflow_count,
    output logic                       full,
    output logic                       bram_clk,
    output logic                       bram_rst,
    output logic                       bram_en,
    output logic [3:0]                 bram_we,
    output logic [BRAM_ADDR_WIDTH-1:0] bram_addr,
    output logic [BRAM_DATA_WIDTH-1:0] bram_din
);

`ifdef BRAM_STREAM_WRITER_DROP_ON_FULL_EN
    localparam bit DROP_ON_FULL = 1'b1;
`else
    localparam bit DROP_ON_FULL = 1'b0;
`endif

    localparam logic [PTR_W-1:0] BLK_MASK = PTR_W'(BLOCK_WORDS - 1);

    state_t           state;
    state_t           next_state;
    logic [PTR_W-1:0] wr_next;
    logic             accept;
    logic             blk_end;

    assign bram_clk = clk;
    assign bram_rst = rst;

    assign wr_next = PTR_W'(next_index(32'(wr_ptr), DEPTH));
    assign full    = rd_ptr[PTR_W] || (wr_next == rd_ptr[PTR_W-1:0]);
    assign accept  = s_valid && s_ready;
    assign blk_end = (wr_ptr & BLK_MASK) == BLK_MASK;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        s_ready    = 1'b0;
        case (state)
            IDLE: begin
                if (enable) next_state = RUN;
            end
            RUN: begin
                s_ready = DROP_ON_FULL ? 1'b1 : !full;
                if (!enable) next_state = STOP;
            end
            STOP: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Write strobes are registered, so a word accepted in cycle N lands in cycle N+1.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr         <= '0;
            block_irq      <= 1'b0;
            block_count    <= '0;
            overflow_count <= '0;
            bram_en        <= 1'b0;
            bram_we        <= 4'h0;
            bram_addr      <= '0;
            bram_din       <= '0;
        end else begin
            bram_en   <= 1'b0;
            bram_we   <= 4'h0;
            block_irq <= 1'b0;
            if (state == IDLE && clear) begin
                wr_ptr         <= '0;
                block_count    <= '0;
                overflow_count <= '0;
            end
            if (accept && !full) begin
                bram_en   <= 1'b1;
                bram_we   <= 4'hF;
                bram_addr <= BRAM_ADDR_WIDTH'({wr_ptr, 2'b00});
                bram_din  <= s_data;
                wr_ptr    <= wr_next;
                if (blk_end) begin
                    block_irq   <= 1'b1;
                    block_count <= block_count + 32'd1;
                end
            end else if (accept && overflow_count != '1) begin
                overflow_count <= overflow_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_bram_stream_writer.sv
// Scoreboard bench for bram_stream_writer with a small buffer (DEPTH=16, BLOCK_WORDS=4).
module tb_bram_stream_writer;

    localparam int DEPTH = 16;
    localparam int BLK   = 4;
    localparam int AW    = 16;
    localparam int PW    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          clear = 1'b0;
    logic [31:0]   s_data = 32'h0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [PW:0]   rd_ptr = '0;
    logic [PW-1:0] wr_ptr;
    logic          block_irq;
    logic [31:0]   block_count;
    logic [31:0]   overflow_count;
    logic          full;
    logic          bram_clk;
    logic          bram_rst;
    logic          bram_en;
    logic [3:0]    bram_we;
    logic [AW-1:0] bram_addr;
    logic [31:0]   bram_din;

    bram_stream_writer #(
        .BRAM_ADDR_WIDTH(AW),
        .BRAM_DATA_WIDTH(32),
        .DEPTH(DEPTH),
        .BLOCK_WORDS(BLK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .clear(clear),
        .s_data(s_data),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .rd_ptr(rd_ptr),
        .wr_ptr(wr_ptr),
        .block_irq(block_irq),
        .block_count(block_count),
        .overflow_count(overflow_count),
        .full(full),
        .bram_clk(bram_clk),
        .bram_rst(bram_rst),
        .bram_en(bram_en),
        .bram_we(bram_we),
        .bram_addr(bram_addr),
        .bram_din(bram_din)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic          irq;
    } wr_t;

    wr_t           exp_q[$];
    int            m_state  = 0;
    logic [PW-1:0] m_wr     = '0;
    logic [31:0]   m_blocks = '0;
    logic [31:0]   m_ovf    = '0;
    int            irq_seen = 0;
    bit            mon_on   = 1'b0;

`ifdef BRAM_STREAM_WRITER_DROP_ON_FULL_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    // Reference model: checks this cycle's outputs, then advances to the next edge.
    always @(negedge clk) begin
        bit  mf;
        bit  mr;
        bit  acc;
        wr_t e;
        if (mon_on) begin
            mf = (int'(rd_ptr) >= DEPTH) || (((int'(m_wr) + 1) % DEPTH) == int'(rd_ptr));
            mr = (m_state == 1) && (DROP || !mf);
            check("wr_ptr", 64'(wr_ptr), 64'(m_wr));
            check("full", 64'(full), 64'(mf));
            check("s_ready", 64'(s_ready), 64'(mr));
            check("block_count", 64'(block_count), 64'(m_blocks));
            check("overflow_count", 64'(overflow_count), 64'(m_ovf));
            if (block_irq) irq_seen++;
            if (bram_en || bram_we != 4'h0) begin
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("bram_en", 64'(bram_en), 64'(1));
                    check("bram_we", 64'(bram_we), 64'(4'hF));
                    check("bram_addr", 64'(bram_addr), 64'(e.addr));
                    check("bram_din", 64'(bram_din), 64'(e.data));
                    check("block_irq", 64'(block_irq), 64'(e.irq));
                end else begin
                    check("spurious_write", 64'({bram_en, bram_we}), 64'(0));
                end
            end else begin
                check("missing_write", 64'(exp_q.size()), 64'(0));
                check("block_irq_idle", 64'(block_irq), 64'(0));
                exp_q.delete();
            end
            if (rst) begin
                m_state  = 0;
                m_wr     = '0;
                m_blocks = '0;
                m_ovf    = '0;
                exp_q.delete();
            end else begin
                acc = s_valid && mr;
                if (acc && !mf) begin
                    e.addr = AW'({m_wr, 2'b00});
                    e.data = s_data;
                    e.irq  = (m_wr[1:0] == 2'b11);
                    exp_q.push_back(e);
                    if (e.irq) m_blocks = m_blocks + 32'd1;
                    m_wr = m_wr + 4'd1;
                end else if (acc && m_ovf != 32'hFFFF_FFFF) begin
                    m_ovf = m_ovf + 32'd1;
                end
                if (m_state == 0 && clear) begin
                    m_wr     = '0;
                    m_blocks = '0;
                    m_ovf    = '0;
                end
                case (m_state)
                    0:       if (enable) m_state = 1;
                    1:       if (!enable) m_state = 2;
                    default: m_state = 0;
                endcase
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offers consecutive words until n are accepted or the cycle budget runs out.
    task automatic send_words(input int n, input logic [31:0] base, input int budget, output int acc);
        acc     = 0;
        s_valid = 1'b1;
        s_data  = base;
        for (int c = 0; c < budget && acc < n; c++) begin
            @(negedge clk);
            if (s_ready) acc++;
            @(posedge clk);
            #1;
            s_data = base + 32'(acc);
        end
        s_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
    endtask

    initial begin
        int acc;
        int irq0;
        tick(3);
        rst = 1'b0;
        check("rst_wr_ptr", 64'(wr_ptr), 64'(0));
        check("rst_s_ready", 64'(s_ready), 64'(0));
        check("rst_bram_en", 64'(bram_en), 64'(0));
        check("rst_bram_we", 64'(bram_we), 64'(0));
        check("rst_bram_addr", 64'(bram_addr), 64'(0));
        check("rst_bram_din", 64'(bram_din), 64'(0));
        check("rst_block_irq", 64'(block_irq), 64'(0));
        check("rst_block_count", 64'(block_count), 64'(0));
        check("rst_overflow", 64'(overflow_count), 64'(0));
        check("rst_full", 64'(full), 64'(0));
        mon_on = 1'b1;

        // Four words land at byte addresses 0x0..0xC.
        enable = 1'b1;
        send_words(4, 32'h0, 20, acc);
        check("t1_accepts", 64'(acc), 64'(4));
        tick(2);
        check("t1_wr_ptr", 64'(wr_ptr), 64'(4));
        check("t1_blocks", 64'(block_count), 64'(1));

        enable = 1'b0;
        tick(3);
        pulse_clear();
        check("clr_wr_ptr", 64'(wr_ptr), 64'(0));
        check("clr_blocks", 64'(block_count), 64'(0));

        // Fill to full with rd_ptr=0: 15 words, blocks at 3, 7, 11.
        enable = 1'b1;
        irq0 = irq_seen;
        send_words(20, 32'h100, 25, acc);
        check("fill_accepts", 64'(acc), 64'(15));
        check("fill_full", 64'(full), 64'(1));
        check("fill_irqs", 64'(irq_seen - irq0), 64'(3));

        // Free half the buffer: 8 back-to-back writes at 15,0..6, blocks at 15 and 3.
        rd_ptr = 5'd8;
        irq0 = irq_seen;
        send_words(8, 32'h200, 8, acc);
        check("wrap_accepts", 64'(acc), 64'(8));
        tick(2);
        check("wrap_irqs", 64'(irq_seen - irq0), 64'(2));
        check("wrap_wr_ptr", 64'(wr_ptr), 64'(7));

        // Out-of-range read pointer stalls writes until corrected.
        rd_ptr = 5'(DEPTH + 3);
        tick(1);
        check("bad_rd_full", 64'(full), 64'(1));
        send_words(3, 32'h300, 6, acc);
        check("bad_rd_accepts", 64'(acc), 64'(0));
        rd_ptr = 5'd7;
        send_words(3, 32'h310, 10, acc);
        check("resume_accepts", 64'(acc), 64'(3));

        // Reset while a write is on the port.
        send_words(1, 32'h400, 5, acc);
        check("pre_rst_we", 64'(bram_we), 64'(4'hF));
        rst = 1'b1;
        tick(1);
        check("mid_rst_we", 64'(bram_we), 64'(0));
        check("mid_rst_wr_ptr", 64'(wr_ptr), 64'(0));
        check("mid_rst_blocks", 64'(block_count), 64'(0));
        rst = 1'b0;

        // Clear in IDLE after two blocks; clear in RUN is ignored.
        rd_ptr = 5'd0;
        send_words(8, 32'h500, 20, acc);
        enable = 1'b0;
        tick(3);
        check("two_blocks", 64'(block_count), 64'(2));
        pulse_clear();
        check("idle_clr_blocks", 64'(block_count), 64'(0));
        check("idle_clr_wr_ptr", 64'(wr_ptr), 64'(0));
        enable = 1'b1;
        send_words(2, 32'h600, 10, acc);
        pulse_clear();
        tick(1);
        check("run_clr_wr_ptr", 64'(wr_ptr), 64'(2));

`ifdef BRAM_STREAM_WRITER_DROP_ON_FULL_EN
        rd_ptr = 5'd3;
        tick(1);
        check("drop_full", 64'(full), 64'(1));
        send_words(5, 32'h700, 5, acc);
        check("drop_accepts", 64'(acc), 64'(5));
        tick(2);
        check("drop_overflow", 64'(overflow_count), 64'(5));
        check("drop_wr_ptr", 64'(wr_ptr), 64'(2));
`endif

        enable = 1'b0;
        tick(4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

endmodule
